// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared op-codes, FSM state type and default width for the
//            alu_mdu_seq execute unit.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int XLEN_DEF = 32;

  // {M-ext select, funct7[5], funct3}
  typedef enum logic [4:0] {
    OP_ADD    = 5'b0_0000,
    OP_SLL    = 5'b0_0001,
    OP_SLT    = 5'b0_0010,
    OP_SLTU   = 5'b0_0011,
    OP_XOR    = 5'b0_0100,
    OP_SRL    = 5'b0_0101,
    OP_OR     = 5'b0_0110,
    OP_AND    = 5'b0_0111,
    OP_SUB    = 5'b0_1000,
    OP_SRA    = 5'b0_1101,
    OP_PASSB  = 5'b0_1111,
    OP_MUL    = 5'b1_0000,
    OP_MULH   = 5'b1_0001,
    OP_MULHSU = 5'b1_0010,
    OP_MULHU  = 5'b1_0011,
    OP_DIV    = 5'b1_0100,
    OP_DIVU   = 5'b1_0101,
    OP_REM    = 5'b1_0110,
    OP_REMU   = 5'b1_0111
  } alu_op_e;

  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_mdu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_mdu_seq_if
// Purpose  : Request/response handshake bundle of the execute unit.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_mdu_seq_if #(
  parameter int XLEN = alu_pkg::XLEN_DEF
) ();
  logic            valid_i;
  logic            ready_o;
  logic [4:0]      AluOp_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] Result_o;
  logic            busy_o;

  modport slave (
    input  valid_i, AluOp_i, rs1_i, rs2_i, ready_i,
    output ready_o, valid_o, Result_o, busy_o
  );

  modport master (
    output valid_i, AluOp_i, rs1_i, rs2_i, ready_i,
    input  ready_o, valid_o, Result_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/alu_mdu_seq_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter
// Purpose  : 1 bit/cycle shift-add multiplier and restoring divider with
//            magnitude conversion at start and sign fix-up on the final step.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              run_q, run_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic              a_signed, b_signed, neg_a, neg_b;
  logic [XLEN:0]     sum, shifted, diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hi_q <= '0; lo_q <= '0; b_q <= '0; cnt_q <= '0; op_q <= '0;
      run_q <= 1'b0; neg_res_q <= 1'b0; neg_rem_q <= 1'b0;
    end else begin
      hi_q <= hi_d; lo_q <= lo_d; b_q <= b_d; cnt_q <= cnt_d; op_q <= op_d;
      run_q <= run_d; neg_res_q <= neg_res_d; neg_rem_q <= neg_rem_d;
    end
  end

  always_comb begin
    a_signed  = (op_i != M_MULHU) && (op_i != M_DIVU) && (op_i != M_REMU);
    b_signed  = (op_i == M_MUL) || (op_i == M_MULH) || (op_i == M_DIV) || (op_i == M_REM);
    neg_a     = a_signed & a_i[XLEN-1];
    neg_b     = b_signed & b_i[XLEN-1];
    sum       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted   = {hi_q, lo_q[XLEN-1]};
    diff      = shifted - {1'b0, b_q};
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    run_d     = run_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    done_o    = 1'b0;
    if (start_i) begin
      run_d     = 1'b1;
      cnt_d     = '0;
      op_d      = op_i;
      hi_d      = '0;
      lo_d      = neg_a ? -a_i : a_i;
      b_d       = neg_b ? -b_i : b_i;
      neg_res_d = neg_a ^ neg_b;
      neg_rem_d = neg_a;
    end else if (run_q) begin
      cnt_d = cnt_q + 1'b1;
      if (op_q[2]) begin
        if (!diff[XLEN]) begin
          hi_d = diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = shifted[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        // Multiplier bits leave lo from the bottom while product bits enter from the top.
        hi_d = sum[XLEN:1];
        lo_d = {sum[0], lo_q[XLEN-1:1]};
      end
      if (cnt_d == CNT_W'(XLEN)) begin
        run_d  = 1'b0;
        done_o = 1'b1;
      end
    end
  end

  // Result is taken from the final step's next-state values so it lands on DONE entry.
  always_comb begin
    prod = {hi_d, lo_d};
    if (neg_res_q) prod = -prod;
    quo = neg_res_q ? -lo_d : lo_d;
    rem = neg_rem_q ? -hi_d : hi_d;
    case (op_q)
      M_MUL:                     result_o = prod[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: result_o = prod[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:             result_o = quo;
      default:                   result_o = rem;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/alu_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mdu_seq
// Purpose  : RV base ALU + RV-M execute unit with registered, handshaked result.
//            Define MDU_FAST_MUL_EN for single-cycle multiplies.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  alu_mdu_seq_if.slave  bus
);
  localparam int              SH_W    = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] alu_res, quick_res, mdu_res;
  logic [SH_W-1:0] shamt;
  logic [2:0]      mop;
  logic            accept, is_div, div_zero, div_ovf, iter_op, mdu_done;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = iter_op ? BUSY : DONE;
      BUSY:    if (mdu_done) state_d = DONE;
      DONE: begin
        if (accept)           state_d = iter_op ? BUSY : DONE;
        else if (bus.ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready_o  = (state_q == IDLE) || ((state_q == DONE) && bus.ready_i);
    bus.valid_o  = (state_q == DONE);
    bus.busy_o   = (state_q == BUSY);
    bus.Result_o = result_q;
  end

  always_comb begin
    shamt = bus.rs2_i[SH_W-1:0];
    case (bus.AluOp_i)
      OP_ADD:   alu_res = bus.rs1_i + bus.rs2_i;
      OP_SUB:   alu_res = bus.rs1_i - bus.rs2_i;
      OP_SLL:   alu_res = bus.rs1_i << shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(bus.rs1_i) < $signed(bus.rs2_i)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, bus.rs1_i < bus.rs2_i};
      OP_XOR:   alu_res = bus.rs1_i ^ bus.rs2_i;
      OP_SRL:   alu_res = bus.rs1_i >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(bus.rs1_i) >>> shamt);
      OP_OR:    alu_res = bus.rs1_i | bus.rs2_i;
      OP_AND:   alu_res = bus.rs1_i & bus.rs2_i;
      OP_PASSB: alu_res = bus.rs2_i;
      default:  alu_res = '0;
    endcase
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]   fast_res;

  // Low 2*XLEN bits of the sign-extended product are exact for every signedness mix.
  always_comb begin
    fast_a    = {{XLEN{(mop != M_MULHU) & bus.rs1_i[XLEN-1]}}, bus.rs1_i};
    fast_b    = {{XLEN{((mop == M_MUL) || (mop == M_MULH)) & bus.rs2_i[XLEN-1]}}, bus.rs2_i};
    fast_prod = fast_a * fast_b;
    fast_res  = (mop == M_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  always_comb begin
    mop      = bus.AluOp_i[2:0];
    is_div   = mop[2];
    div_zero = is_div && (bus.rs2_i == '0);
    div_ovf  = is_div && !mop[0] && (bus.rs1_i == MIN_INT) && (bus.rs2_i == '1);
`ifdef MDU_FAST_MUL_EN
    iter_op  = bus.AluOp_i[4] && is_div && !div_zero && !div_ovf;
`else
    iter_op  = bus.AluOp_i[4] && !div_zero && !div_ovf;
`endif
    quick_res = alu_res;
    if (bus.AluOp_i[4]) begin
      if (div_zero)     quick_res = mop[1] ? bus.rs1_i : '1;
      else if (div_ovf) quick_res = mop[1] ? '0 : MIN_INT;
`ifdef MDU_FAST_MUL_EN
      else if (!is_div) quick_res = fast_res;
`endif
      else              quick_res = '0;
    end
    accept   = bus.valid_i && bus.ready_o;
    result_d = result_q;
    if (accept && !iter_op) result_d = quick_res;
    else if (mdu_done)      result_d = mdu_res;
  end

  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (accept && iter_op),
    .op_i     (mop),
    .a_i      (bus.rs1_i),
    .b_i      (bus.rs2_i),
    .done_o   (mdu_done),
    .result_o (mdu_res)
  );
endmodule
`default_nettype wire

// File: tb/tb_alu_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mdu_seq
// Purpose  : Self-checking bench for alu_mdu_seq against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mdu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_mdu_seq_if #(.XLEN(32)) bus ();

  alu_mdu_seq #(.XLEN(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int          ia, ib;
    longint      p;
    logic [63:0] pu;
    ia = a;
    ib = b;
    if (!op[4]) begin
      case (op)
        5'b0_0000: return a + b;
        5'b0_1000: return a - b;
        5'b0_0001: return a << b[4:0];
        5'b0_0010: return (ia < ib) ? 32'd1 : 32'd0;
        5'b0_0011: return (a < b) ? 32'd1 : 32'd0;
        5'b0_0100: return a ^ b;
        5'b0_0101: return a >> b[4:0];
        5'b0_1101: return ia >>> b[4:0];
        5'b0_0110: return a | b;
        5'b0_0111: return a & b;
        5'b0_1111: return b;
        default:   return 32'd0;
      endcase
    end
    case (op[2:0])
      3'b000: begin p = longint'(ia) * longint'(ib); return p[31:0]; end
      3'b001: begin p = longint'(ia) * longint'(ib); return p[63:32]; end
      3'b010: begin p = longint'(ia) * longint'({32'd0, b}); return p[63:32]; end
      3'b011: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[4]) return 1;
    if (op[2]) begin
      if (b == 0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef MDU_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  // Issues one op, measures latency/busy cycles, optionally stalls the consumer.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int          lat, busy_cnt, exp_lat;
    logic [31:0] exp_res;
    exp_res = model(op, a, b);
    exp_lat = model_lat(op, a, b);
    @(negedge clk);
    check_eq({tag, ".ready_in"}, {31'd0, bus.ready_o}, 32'd1);
    bus.valid_i = 1'b1;
    bus.AluOp_i = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    bus.ready_i = (hold == 0);
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.AluOp_i = 5'($urandom);
    bus.rs1_i   = $urandom;
    bus.rs2_i   = $urandom;
    lat = 1;
    busy_cnt = 0;
    while (!bus.valid_o && lat < 200) begin
      busy_cnt += int'(bus.busy_o);
      @(negedge clk);
      lat++;
    end
    check_eq({tag, ".latency"}, lat, exp_lat);
    check_eq({tag, ".busy"}, busy_cnt, exp_lat - 1);
    check_eq({tag, ".result"}, bus.Result_o, exp_res);
    check_eq({tag, ".ready_out"}, {31'd0, bus.ready_o}, (hold == 0) ? 32'd1 : 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.valid_i = 1'b1;
      bus.AluOp_i = 5'($urandom);
      bus.rs1_i   = $urandom;
      bus.rs2_i   = $urandom;
      @(negedge clk);
      check_eq({tag, ".hold_valid"}, {31'd0, bus.valid_o}, 32'd1);
      check_eq({tag, ".hold_result"}, bus.Result_o, exp_res);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
  endtask

  logic [4:0]  ops [19] = '{5'h00, 5'h08, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h0D, 5'h06,
                            5'h07, 5'h0F, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17};
  logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

  function automatic logic [31:0] rand_operand();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    int          vcount;
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    bus.AluOp_i = '0;
    bus.rs1_i   = '0;
    bus.rs2_i   = '0;
    repeat (3) @(negedge clk);
    check_eq("rst.valid", {31'd0, bus.valid_o}, 32'd0);
    check_eq("rst.result", bus.Result_o, 32'd0);
    check_eq("rst.ready", {31'd0, bus.ready_o}, 32'd1);
    check_eq("rst.busy", {31'd0, bus.busy_o}, 32'd0);
    rst_n = 1'b1;

    run_op("add_wrap", 5'h00, 32'h7FFF_FFFF, 32'h1, 0);
    run_op("sra", 5'h0D, 32'h8000_0000, 32'h24, 0);
    run_op("div_neg", 5'h14, 32'hFFFF_FFF9, 32'h2, 0);
    run_op("rem_neg", 5'h16, 32'hFFFF_FFF9, 32'h2, 0);
    run_op("divu_zero", 5'h15, 32'h5, 32'h0, 0);
    run_op("rem_zero", 5'h16, 32'h5, 32'h0, 0);
    run_op("div_ovf", 5'h14, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", 5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("unlisted", 5'h09, 32'h1234_5678, 32'h1, 0);

    // Back-to-back: a new op accepted in the same cycle the previous result is taken.
    @(negedge clk);
    bus.valid_i = 1'b1; bus.AluOp_i = 5'h00; bus.rs1_i = 32'd3; bus.rs2_i = 32'd4;
    @(negedge clk);
    check_eq("b2b.first", bus.Result_o, model(5'h00, 32'd3, 32'd4));
    bus.AluOp_i = 5'h08; bus.rs1_i = 32'd10; bus.rs2_i = 32'd3;
    @(negedge clk);
    check_eq("b2b.second_valid", {31'd0, bus.valid_o}, 32'd1);
    check_eq("b2b.second", bus.Result_o, model(5'h08, 32'd10, 32'd3));
    bus.valid_i = 1'b0;

    for (int n = 0; n < 80; n++) begin
      rop = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 18)];
      ra  = rand_operand();
      rb  = rand_operand();
      run_op($sformatf("rnd%0d_op%02h", n, rop), rop, ra, rb,
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    run_op("mulhu_hold", 5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);

    // Reset in the middle of an iterative divide.
    @(negedge clk);
    bus.valid_i = 1'b1; bus.AluOp_i = 5'h14; bus.rs1_i = 32'd100; bus.rs2_i = 32'd7;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort.valid", {31'd0, bus.valid_o}, 32'd0);
    check_eq("abort.result", bus.Result_o, 32'd0);
    check_eq("abort.ready", {31'd0, bus.ready_o}, 32'd1);
    check_eq("abort.busy", {31'd0, bus.busy_o}, 32'd0);
    rst_n = 1'b1;
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      vcount += int'(bus.valid_o);
    end
    check_eq("abort.no_result", vcount, 32'd0);
    run_op("post_abort", 5'h15, 32'd100, 32'd7, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
